// File: rtl/dot_prod_serial.sv
// dot_prod_serial: serial complex dot product sum_k x[k]*conj(y[k]).
// One complex MAC per clock; the result leaves on a valid/ready pair.
module dot_prod_serial #(
  parameter int LENGTH  = 4,
  parameter int XI_BITS = 12,
  parameter int XQ_BITS = 12,
  parameter int YI_BITS = 12,
  parameter int YQ_BITS = 12,
  parameter int I_BITS  = XI_BITS + YI_BITS + 1 + $clog2(LENGTH),
  parameter int Q_BITS  = XQ_BITS + YI_BITS + 1 + $clog2(LENGTH)
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic                        m_axis_x_tvalid,
  output logic                        m_axis_x_tready,
  input  logic [XI_BITS*LENGTH-1:0]   xi,
  input  logic [XQ_BITS*LENGTH-1:0]   xq,
  input  logic                        m_axis_y_tvalid,
  output logic                        m_axis_y_tready,
  input  logic [YI_BITS*LENGTH-1:0]   yi,
  input  logic [YQ_BITS*LENGTH-1:0]   yq,
  output logic                        s_axis_tvalid,
  input  logic                        m_axis_product_tready,
  output logic [I_BITS-1:0]           i,
  output logic [Q_BITS-1:0]           q
);

  localparam int XW = (XI_BITS > XQ_BITS) ? XI_BITS : XQ_BITS;
  localparam int YW = (YI_BITS > YQ_BITS) ? YI_BITS : YQ_BITS;
  localparam int AF = XW + YW + 1 + $clog2(LENGTH);
  localparam int AI = (AF > I_BITS) ? AF : I_BITS;
  localparam int AW = (AI > Q_BITS) ? AI : Q_BITS;
  localparam int CW = $clog2(LENGTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [AW-1:0] acc_i_q, acc_i_d;
  logic signed [AW-1:0] acc_q_q, acc_q_d;
  logic [XI_BITS*LENGTH-1:0] xi_q, xi_d;
  logic [XQ_BITS*LENGTH-1:0] xq_q, xq_d;
  logic [YI_BITS*LENGTH-1:0] yi_q, yi_d;
  logic [YQ_BITS*LENGTH-1:0] yq_q, yq_d;
  logic [I_BITS-1:0] i_q, i_d;
  logic [Q_BITS-1:0] q_q, q_d;
  logic vld_q, vld_d;

  logic signed [XI_BITS-1:0] exi;
  logic signed [XQ_BITS-1:0] exq;
  logic signed [YI_BITS-1:0] eyi;
  logic signed [YQ_BITS-1:0] eyq;
  logic signed [AW-1:0] pi, pq;

  assign exi = xi_q[int'(cnt_q)*XI_BITS +: XI_BITS];
  assign exq = xq_q[int'(cnt_q)*XQ_BITS +: XQ_BITS];
  assign eyi = yi_q[int'(cnt_q)*YI_BITS +: YI_BITS];
  assign eyq = yq_q[int'(cnt_q)*YQ_BITS +: YQ_BITS];

  // operands widened first so products and sums never overflow
  assign pi = (AW'(exi) * AW'(eyi)) + (AW'(exq) * AW'(eyq));
  assign pq = (AW'(exq) * AW'(eyi)) - (AW'(exi) * AW'(eyq));

  assign m_axis_x_tready = n_reset && (state_q == IDLE) && m_axis_y_tvalid;
  assign m_axis_y_tready = n_reset && (state_q == IDLE) && m_axis_x_tvalid;
  assign s_axis_tvalid   = vld_q;
  assign i               = i_q;
  assign q               = q_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    xi_d    = xi_q;
    xq_d    = xq_q;
    yi_d    = yi_q;
    yq_d    = yq_q;
    i_d     = i_q;
    q_d     = q_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (m_axis_x_tvalid && m_axis_y_tvalid) begin
          xi_d    = xi;
          xq_d    = xq;
          yi_d    = yi;
          yq_d    = yq;
          acc_i_d = '0;
          acc_q_d = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_i_d = acc_i_q + pi;
        acc_q_d = acc_q_q + pq;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(LENGTH - 1)) begin
          i_d     = acc_i_d[I_BITS-1:0];
          q_d     = acc_q_d[Q_BITS-1:0];
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (m_axis_product_tready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      xi_q    <= '0;
      xq_q    <= '0;
      yi_q    <= '0;
      yq_q    <= '0;
      i_q     <= '0;
      q_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      xi_q    <= xi_d;
      xq_q    <= xq_d;
      yi_q    <= yi_d;
      yq_q    <= yq_d;
      i_q     <= i_d;
      q_q     <= q_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_dot_prod_serial.sv
// tb_dot_prod_serial: directed and random vectors for dot_prod_serial,
// checked against an arithmetic model of sum x[k]*conj(y[k]).
module tb_dot_prod_serial;

  localparam int LEN = 4;
  localparam int W   = 12;
  localparam int OW  = 27;

  logic clk = 1'b0;
  logic n_reset;
  logic xv, yv, xr, yr, ov, prdy;
  logic [W*LEN-1:0] xi, xq, yi, yq;
  logic [OW-1:0] res_i, res_q;

  int n_vec = 0;
  int n_err = 0;

  int vxi[32][LEN];
  int vxq[32][LEN];
  int vyi[32][LEN];
  int vyq[32][LEN];

  always #5 clk = ~clk;

  dot_prod_serial dut (
    .clk                   (clk),
    .n_reset               (n_reset),
    .m_axis_x_tvalid       (xv),
    .m_axis_x_tready       (xr),
    .xi                    (xi),
    .xq                    (xq),
    .m_axis_y_tvalid       (yv),
    .m_axis_y_tready       (yr),
    .yi                    (yi),
    .yq                    (yq),
    .s_axis_tvalid         (ov),
    .m_axis_product_tready (prdy),
    .i                     (res_i),
    .q                     (res_q)
  );

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint si();
    return longint'($signed(res_i));
  endfunction

  function automatic longint sq();
    return longint'($signed(res_q));
  endfunction

  function automatic longint mod_i(input int v);
    longint s = 0;
    for (int k = 0; k < LEN; k++)
      s += longint'(vxi[v][k]) * vyi[v][k] + longint'(vxq[v][k]) * vyq[v][k];
    return s;
  endfunction

  function automatic longint mod_q(input int v);
    longint s = 0;
    for (int k = 0; k < LEN; k++)
      s += longint'(vxq[v][k]) * vyi[v][k] - longint'(vxi[v][k]) * vyq[v][k];
    return s;
  endfunction

  task automatic set_vec(input int v, input int a, input int b,
                         input int c, input int d);
    for (int k = 0; k < LEN; k++) begin
      vxi[v][k] = a;
      vxq[v][k] = b;
      vyi[v][k] = c;
      vyq[v][k] = d;
    end
  endtask

  task automatic rnd_vec(input int v);
    for (int k = 0; k < LEN; k++) begin
      vxi[v][k] = int'($urandom_range(4095)) - 2048;
      vxq[v][k] = int'($urandom_range(4095)) - 2048;
      vyi[v][k] = int'($urandom_range(4095)) - 2048;
      vyq[v][k] = int'($urandom_range(4095)) - 2048;
    end
  endtask

  task automatic load(input int v);
    for (int k = 0; k < LEN; k++) begin
      xi[k*W +: W] = W'(vxi[v][k]);
      xq[k*W +: W] = W'(vxq[v][k]);
      yi[k*W +: W] = W'(vyi[v][k]);
      yq[k*W +: W] = W'(vyq[v][k]);
    end
    xv = 1'b1;
    yv = 1'b1;
  endtask

  task automatic drop();
    xv = 1'b0;
    yv = 1'b0;
    xi = (W*LEN)'({$urandom, $urandom});
    xq = (W*LEN)'({$urandom, $urandom});
    yi = (W*LEN)'({$urandom, $urandom});
    yq = (W*LEN)'({$urandom, $urandom});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one vector: capture, latency, optional output stall, transfer
  task automatic one_vec(input int v, input int hold, input int nxt);
    int t = 0;
    longint hi, hq;
    load(v);
    prdy = (hold == 0);
    #1;
    while (!(xr && yr) && t < 20) begin
      tick();
      t++;
    end
    if (t == 20) begin
      chk("cap_timeout", 0, 1);
      drop();
      return;
    end
    tick();
    if (nxt >= 0) load(nxt);
    else drop();
    for (int e = 1; e <= LEN; e++) begin
      tick();
      chk("latency", longint'(ov), longint'(e == LEN));
      chk("rdy_busy", longint'(xr | yr), 0);
    end
    chk("res_i", si(), mod_i(v));
    chk("res_q", sq(), mod_q(v));
    hi = si();
    hq = sq();
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("stall_vld", longint'(ov), 1);
      chk("stall_i", si(), hi);
      chk("stall_q", sq(), hq);
      chk("stall_rdy", longint'(xr | yr), 0);
    end
    prdy = 1'b1;
    tick();
    chk("xfer_vld", longint'(ov), 0);
    chk("keep_i", si(), hi);
    chk("keep_q", sq(), hq);
    if (nxt >= 0) chk("recapture", longint'(xr & yr), 1);
  endtask

  // stream n vectors from base with valids held; rnd selects random ready
  task automatic stream(input int base, input int n, input bit rnd);
    int idx = 0;
    int r = 0;
    int cyc = 0;
    int last = 0;
    bit pend = 0;
    bit capt, xfer;
    longint li = 0, lq = 0;
    load(base);
    prdy = 1'b1;
    #1;
    while (r < n && cyc < 12 * n + 40) begin
      if (rnd) begin
        prdy = 1'($urandom_range(1));
        #1;
      end
      if (ov) begin
        chk("st_rdy", longint'(xr | yr), 0);
        if (pend) begin
          chk("st_hold_i", si(), li);
          chk("st_hold_q", sq(), lq);
        end
      end
      xfer = ov && prdy;
      if (xfer) begin
        chk("st_i", si(), mod_i(base + r));
        chk("st_q", sq(), mod_q(base + r));
        if (!rnd && r > 0) chk("st_gap", longint'(cyc - last), LEN + 2);
        last = cyc;
        r++;
      end
      capt = xr && yr;
      pend = ov && !prdy;
      li = si();
      lq = sq();
      if (r < n) begin
        tick();
        cyc++;
        if (capt) begin
          idx++;
          if (idx < n) load(base + idx);
          else drop();
        end
      end
    end
    chk("st_count", longint'(r), longint'(n));
    drop();
    prdy = 1'b1;
    tick();
  endtask

  initial begin
    n_reset = 1'b0;
    prdy    = 1'b1;
    xi = '0;
    xq = '0;
    yi = '0;
    yq = '0;
    xv = 1'b1;
    yv = 1'b1;
    set_vec(0, 1, 2, 3, 4);
    set_vec(1, -2048, -2048, -2048, -2048);
    for (int v = 2; v < 32; v++) rnd_vec(v);

    tick();
    tick();
    chk("rst_vld", longint'(ov), 0);
    chk("rst_i", si(), 0);
    chk("rst_q", sq(), 0);
    chk("rst_xr", longint'(xr), 0);
    chk("rst_yr", longint'(yr), 0);
    n_reset = 1'b1;
    drop();
    tick();

    one_vec(0, 0, -1);
    one_vec(1, 0, -1);
    one_vec(2, 6, 3);
    one_vec(3, 0, -1);

    load(4);
    yv = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("lone_xr", longint'(xr), 0);
      chk("lone_vld", longint'(ov), 0);
    end
    yv = 1'b1;
    #1;
    chk("pair_rdy", longint'(xr & yr), 1);
    one_vec(4, 0, -1);

    load(5);
    #1;
    tick();
    drop();
    tick();
    n_reset = 1'b0;
    xv = 1'b1;
    yv = 1'b1;
    tick();
    chk("mid_rst_vld", longint'(ov), 0);
    chk("mid_rst_i", si(), 0);
    chk("mid_rst_q", sq(), 0);
    chk("mid_rst_rdy", longint'(xr | yr), 0);
    n_reset = 1'b1;
    drop();
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("no_partial", longint'(ov), 0);
    end
    one_vec(6, 0, -1);

    stream(7, 2, 1'b0);
    stream(9, 8, 1'b0);
    stream(17, 12, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
